// File: rtl/mem_stage_if.sv
// Signal bundle for the memory stage: execute-side inputs, RAM handshake and write-back outputs.
// The stage itself uses the slave view; its environment uses the master view.
interface mem_stage_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic              datamem_ena;
  logic              memwb_ena;
  logic [2:0]        mem;
  logic [1:0]        st_size;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       mem_w_data;
  logic [63:0]       rd_data_i;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [63:0]       ram_wdata;
  logic [7:0]        ram_wmask;
  logic              ram_ready;
  logic [63:0]       ram_rdata;
  logic              wb_valid;
  logic [63:0]       wb_data;
  logic              misalign;
  logic              bus_err;

  modport slave (
    input  in_valid, datamem_ena, memwb_ena, mem, st_size, addr, mem_w_data, rd_data_i,
    input  ram_ready, ram_rdata,
    output in_ready, ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
    output wb_valid, wb_data, misalign, bus_err
  );

  modport master (
    output in_valid, datamem_ena, memwb_ena, mem, st_size, addr, mem_w_data, rd_data_i,
    output ram_ready, ram_rdata,
    input  in_ready, ram_req, ram_we, ram_addr, ram_wdata, ram_wmask,
    input  wb_valid, wb_data, misalign, bus_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one RAM request per load/store, byte-lane masking for stores,
// alignment and sign/zero extension for loads, pass-through of ALU results otherwise.
module mem_stage #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [2:0]        off_q, off_d;
  logic [2:0]        mem_q, mem_d;
  logic              load_q, load_d;
  logic [63:0]       res_q, res_d;
  logic              mis_q, mis_d;
  logic              berr_q, berr_d;

  logic [1:0]        size_in;
  logic              mis_in;
  logic [7:0]        base_mask;

  // Access size as log2(bytes); code 000 on a load falls through to dword.
  function automatic logic [1:0] acc_size(input logic ld, input logic [2:0] m, input logic [1:0] st);
    if (!ld) return st;
    case (m)
      3'b001, 3'b100: return 2'd0;
      3'b010, 3'b101: return 2'd1;
      3'b011, 3'b110: return 2'd2;
      default:        return 2'd3;
    endcase
  endfunction

  function automatic logic [63:0] load_ext(input logic [63:0] d, input logic [2:0] off, input logic [2:0] m);
    logic [63:0] sh;
    sh = d >> {off, 3'b000};
    case (m)
      3'b001:  return {{56{sh[7]}}, sh[7:0]};
      3'b010:  return {{48{sh[15]}}, sh[15:0]};
      3'b011:  return {{32{sh[31]}}, sh[31:0]};
      3'b100:  return {56'd0, sh[7:0]};
      3'b101:  return {48'd0, sh[15:0]};
      3'b110:  return {32'd0, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    size_in = acc_size(bus.memwb_ena, bus.mem, bus.st_size);
    case (size_in)
      2'd1:    begin mis_in = bus.addr[0];        base_mask = 8'h03; end
      2'd2:    begin mis_in = |bus.addr[1:0];     base_mask = 8'h0F; end
      2'd3:    begin mis_in = |bus.addr[2:0];     base_mask = 8'hFF; end
      default: begin mis_in = 1'b0;               base_mask = 8'h01; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    off_d   = off_q;
    mem_d   = mem_q;
    load_d  = load_q;
    res_d   = res_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = DONE;
          res_d   = '0;
          mis_d   = 1'b0;
          berr_d  = 1'b0;
          if (!bus.datamem_ena) begin
            res_d = bus.rd_data_i;
          end else if (mis_in) begin
            mis_d = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = {bus.addr[ADDR_W-1:3], 3'b000};
            we_d    = !bus.memwb_ena;
            wdata_d = bus.mem_w_data << {bus.addr[2:0], 3'b000};
            wmask_d = base_mask << bus.addr[2:0];
            off_d   = bus.addr[2:0];
            mem_d   = bus.mem;
            load_d  = bus.memwb_ena;
          end
        end
      end
      REQ: begin
        // A ready in the final allowed cycle wins over the timeout.
        if (bus.ram_ready) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = load_q ? load_ext(bus.ram_rdata, off_q, mem_q) : 64'd0;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = DONE;
          cnt_d   = '0;
          berr_d  = 1'b1;
          res_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        res_d   = '0;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      off_q   <= '0;
      mem_q   <= '0;
      load_q  <= 1'b0;
      res_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      off_q   <= off_d;
      mem_q   <= mem_d;
      load_q  <= load_d;
      res_q   <= res_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  // RAM-side fields are only presented while a request is outstanding.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.ram_req   = (state_q == REQ);
  assign bus.ram_we    = bus.ram_req & we_q;
  assign bus.ram_addr  = bus.ram_req ? addr_q  : '0;
  assign bus.ram_wdata = bus.ram_req ? wdata_q : '0;
  assign bus.ram_wmask = bus.ram_req ? wmask_q : '0;
  assign bus.wb_valid  = (state_q == DONE);
  assign bus.wb_data   = bus.wb_valid ? res_q : '0;
  assign bus.misalign  = bus.wb_valid & mis_q;
  assign bus.bus_err   = bus.wb_valid & berr_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a byte-level behavioural model.
module tb_mem_stage;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   txn_id   = 0;

  mem_stage_if #(.ADDR_W(64)) bus ();
  mem_stage #(.ADDR_W(64), .TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int model_nbytes(input logic ld, input logic [2:0] m, input logic [1:0] st);
    if (!ld) return 1 << st;
    case (m)
      3'd1, 3'd4: return 1;
      3'd2, 3'd5: return 2;
      3'd3, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [7:0] model_mask(input int off, input int nb);
    logic [7:0] r = '0;
    for (int b = 0; b < 8; b++) r[b] = (b >= off) && (b < off + nb);
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] d, input int off, input int nb, input logic [2:0] m);
    logic [63:0] v, keep;
    v = d >> (8 * off);
    if (nb < 8) begin
      keep = (64'd1 << (8 * nb)) - 64'd1;
      v = v & keep;
      if ((m >= 3'd1) && (m <= 3'd3) && v[8*nb-1]) v = v | ~keep;
    end
    return v;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.datamem_ena = 1'b0; bus.memwb_ena = 1'b0; bus.mem = 3'd0;
    bus.st_size = 2'd0; bus.addr = '0; bus.mem_w_data = '0; bus.rd_data_i = '0;
    bus.ram_ready = 1'b0; bus.ram_rdata = '0;
  endtask

  // delay = REQ cycles without ready before ready is given; delay >= T never answers.
  task automatic run_txn(input logic dm, input logic ld, input logic [2:0] m, input logic [1:0] st,
                         input logic [63:0] a, input logic [63:0] wd, input logic [63:0] alu,
                         input logic [63:0] rdat, input int delay);
    int nb, off, req_cycles;
    logic mis, to;
    logic [63:0] exp_wb;
    nb  = model_nbytes(ld, m, st);
    off = int'(a % 8);
    mis = dm && ((a % nb) != 0);
    to  = dm && !mis && (delay >= T);
    req_cycles = (!dm || mis) ? 0 : ((delay < T) ? delay + 1 : T);
    if (!dm)            exp_wb = alu;
    else if (mis || to) exp_wb = 64'd0;
    else if (ld)        exp_wb = model_load(rdat, off, nb, m);
    else                exp_wb = 64'd0;

    @(negedge clk);
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1; bus.datamem_ena = dm; bus.memwb_ena = ld; bus.mem = m;
    bus.st_size = st; bus.addr = a; bus.mem_w_data = wd; bus.rd_data_i = alu;
    @(negedge clk);
    for (int c = 0; c < req_cycles; c++) begin
      chk("ram_req", {63'd0, bus.ram_req}, 64'd1);
      chk("in_ready_busy", {63'd0, bus.in_ready}, 64'd0);
      chk("ram_addr", bus.ram_addr, a & ~64'h7);
      chk("ram_we", {63'd0, bus.ram_we}, {63'd0, !ld});
      chk("ram_wmask", {56'd0, bus.ram_wmask}, {56'd0, model_mask(off, nb)});
      chk("ram_wdata", bus.ram_wdata, wd << (8 * off));
      bus.ram_ready = (c == delay);
      bus.ram_rdata = (c == delay) ? rdat : {$urandom, $urandom};
      bus.in_valid  = 1'b1;
      bus.addr      = {$urandom, $urandom};
      bus.mem_w_data = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.ram_ready = 1'b0;
    chk("wb_valid", {63'd0, bus.wb_valid}, 64'd1);
    chk("ram_req_done", {63'd0, bus.ram_req}, 64'd0);
    chk("wb_data", bus.wb_data, exp_wb);
    chk("misalign", {63'd0, bus.misalign}, {63'd0, mis});
    chk("bus_err", {63'd0, bus.bus_err}, {63'd0, to});
    @(negedge clk);
    chk("wb_valid_drop", {63'd0, bus.wb_valid}, 64'd0);
    chk("in_ready_back", {63'd0, bus.in_ready}, 64'd1);
    $display("txn %0d: dm=%0d ld=%0d mem=%0d st=%0d addr=%h delay=%0d wb=%h mis=%0d err=%0d",
             txn_id, dm, ld, m, st, a, delay, exp_wb, mis, to);
    txn_id++;
  endtask

  initial begin
    logic dm, ld;
    logic [2:0] m;
    logic [1:0] st;
    logic [63:0] a;
    int nb, dly;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_ram_req", {63'd0, bus.ram_req}, 64'd0);
    chk("rst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_flags", {62'd0, bus.misalign, bus.bus_err}, 64'd0);
    rst = 1'b1;

    run_txn(1'b0, 1'b0, 3'd0, 2'd0, 64'h0, 64'h0, 64'h1234, 64'h0, 0);
    run_txn(1'b1, 1'b1, 3'd1, 2'd0, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 0);
    run_txn(1'b1, 1'b1, 3'd4, 2'd0, 64'h1003, 64'h0, 64'h0, 64'h0000_0000_8000_0000, 0);
    run_txn(1'b1, 1'b0, 3'd0, 2'd1, 64'h2006, 64'hBEEF, 64'h0, 64'h0, 3);
    run_txn(1'b1, 1'b1, 3'd3, 2'd0, 64'h3002, 64'h0, 64'h0, 64'h0, 0);
    run_txn(1'b1, 1'b1, 3'd7, 2'd0, 64'h4000, 64'h0, 64'h0, 64'h0, 10);
    run_txn(1'b1, 1'b1, 3'd0, 2'd0, 64'h4008, 64'h0, 64'h0, 64'hCAFE_F00D_1234_5678, T - 1);

    // Reset while a request is outstanding.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.datamem_ena = 1'b1; bus.memwb_ena = 1'b1; bus.mem = 3'd7;
    bus.addr = 64'h5000;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_req_active", {63'd0, bus.ram_req}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_ram_req", {63'd0, bus.ram_req}, 64'd0);
    chk("async_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("async_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    run_txn(1'b1, 1'b1, 3'd7, 2'd0, 64'h5000, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 1);

    for (int i = 0; i < 200; i++) begin
      dm = ($urandom_range(0, 3) != 0);
      ld = $urandom_range(0, 1);
      m  = 3'($urandom_range(0, 7));
      st = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      nb = model_nbytes(ld, m, st);
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(nb) - 64'd1);
      dly = ($urandom_range(0, 4) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      run_txn(dm, ld, m, st, a, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, dly);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between the execute stage and write-back, and the consumer of its memory-side outputs: `datamem_ena`, `memwb_ena`, the 3-bit load code and the store data.
- Issues one request per memory instruction to the single-port 64-bit data RAM over a req/ready handshake.
- Builds byte-lane write masks for stores; aligns and sign/zero-extends load data.
- Forwards ALU results unchanged for non-memory instructions.

Parameters:
- ADDR_W, 64, byte address width.
- TIMEOUT, 255, maximum cycles to wait for `ram_ready` before a bus error (1..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute-stage result valid this cycle.
- in_ready  out  1  stage can accept; equals (state==IDLE).
- datamem_ena  in  1  instruction accesses memory.
- memwb_ena  in  1  instruction is a load (result goes to write-back).
- mem  in  3  load code: 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110 LWU, 111 LD, 000 none.
- st_size  in  2  store size: 00 byte, 01 half, 10 word, 11 dword.
- addr  in  ADDR_W  effective byte address.
- mem_w_data  in  64  store data, right-justified.
- rd_data_i  in  64  ALU result.
- ram_req  out  1  RAM request valid.
- ram_we  out  1  1 = write.
- ram_addr  out  ADDR_W  dword-aligned address (addr[2:0] forced to 0).
- ram_wdata  out  64  store data shifted to its byte lane.
- ram_wmask  out  8  byte enables.
- ram_ready  in  1  RAM accepts or completes the request; `ram_rdata` is valid in the same cycle.
- ram_rdata  in  64  read dword.
- wb_valid  out  1  one-cycle pulse: result is available.
- wb_data  out  64  write-back value.
- misalign  out  1  pulses with `wb_valid` when the access was misaligned.
- bus_err  out  1  pulses with `wb_valid` when the RAM timed out.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state=IDLE, timeout counter=0.
  - All outputs 0 except `in_ready`=1.
  - Reset mid-transaction abandons the request and drops `ram_req` immediately.
- States: IDLE, REQ, DONE.
- IDLE, accepting when `in_valid`:
  - `datamem_ena`=0: latch `rd_data_i`, go to DONE. `wb_valid` rises the next cycle (1-cycle latency).
  - `datamem_ena`=1 and misaligned: go to DONE with `misalign`=1 and `wb_data`=0; no RAM access. Misaligned means half with addr[0]≠0, word with addr[1:0]≠0, or dword with addr[2:0]≠0. Access size comes from `mem` for loads and `st_size` for stores.
  - Otherwise: latch addr, size, load code and `memwb_ena`; go to REQ.
- REQ:
  - `ram_req`=1, `ram_we` = !`memwb_ena`; address, wdata and mask registered and held stable until `ram_ready`.
  - `ram_wmask`: byte 8'h01, half 8'h03, word 8'h0F, dword 8'hFF, each shifted left by addr[2:0].
  - `ram_wdata` = `mem_w_data` shifted left by 8*addr[2:0].
  - On `ram_ready`: capture `ram_rdata`, drop `ram_req` next cycle, go to DONE.
  - Timeout counter increments each REQ cycle without `ram_ready`. Reaching TIMEOUT → DONE with `bus_err`=1, `wb_data`=0. Counter clears on leaving REQ.
- DONE:
  - `wb_valid`=1 for exactly one cycle, then IDLE.
  - Loads: shift the captured dword right by 8*addr[2:0], then take the low 8/16/32/64 bits.
    - LB/LH/LW sign-extend.
    - LBU/LHU/LWU zero-extend.
    - LD passes all 64 bits.
  - Stores: `wb_data`=0.
  - Non-memory: `wb_data` = latched `rd_data_i`.
- `in_ready`=0 in REQ and DONE; `in_valid` is ignored while not ready.
- Minimum latency for an accepted memory operation: accept → REQ → DONE = 2 cycles to `wb_valid` when `ram_ready` arrives in the first REQ cycle.
- A `ram_ready` seen in the same cycle the counter reaches TIMEOUT counts as success; no `bus_err`.
- `mem`=000 with `memwb_ena`=1 is treated as LD.

Test Plan:
- Non-memory op: `rd_data_i`=64'h1234, `datamem_ena`=0 → `wb_valid` next cycle with `wb_data`=64'h1234; `ram_req` never asserted.
- LB at addr=0x1003, `ram_rdata`=64'h0000_0000_8000_0000, `ram_ready` in the first REQ cycle → `ram_addr`=0x1000, `wb_data`=64'hFFFF_FFFF_FFFF_FF80; same access as LBU → 64'h80.
- SH at addr=0x2006, `mem_w_data`=64'hBEEF → `ram_we`=1, `ram_wmask`=8'hC0, `ram_wdata`=64'hBEEF_0000_0000_0000; request fields held stable over 3 cycles with `ram_ready`=0.
- LW at addr=0x3002 → `misalign`=1 and `wb_valid` one cycle after accept; no `ram_req`.
- LD with `ram_ready` held 0 and TIMEOUT=4 → `bus_err`=1 after 4 REQ cycles, `wb_data`=0, return to IDLE with `in_ready`=1.
- Assert `rst`=0 mid-REQ → `ram_req`, `wb_valid` and `in_ready` take reset values asynchronously; a new LD after release completes normally.
